// File: rtl/muller_pkg.sv
// Shared types and the C-element update rule for the clocked Muller pipeline.
package muller_pkg;

  localparam int unsigned MULLER_MIN_DEPTH  = 2;
  localparam int unsigned MULLER_MAX_INPUTS = 32;

  typedef logic [MULLER_MAX_INPUTS-1:0] c_state_t;

  // Rise when every used input is 1, fall when every used input is 0, else hold.
  function automatic logic c_next(input c_state_t inputs, input logic current,
                                  input int unsigned n = MULLER_MAX_INPUTS);
    logic all_one;
    logic all_zero;
    all_one  = 1'b1;
    all_zero = 1'b1;
    for (int unsigned i = 0; i < MULLER_MAX_INPUTS; i++) begin
      if (i < n) begin
        all_one  = all_one & inputs[i];
        all_zero = all_zero & ~inputs[i];
      end
    end
    if (all_one) return 1'b1;
    if (all_zero) return 1'b0;
    return current;
  endfunction

endpackage

// File: rtl/muller_pipe_clk_c.sv
// Clocked N-input C-element; also flags the cycle in which its output rises.
module muller_c_clk
  import muller_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_i,
  output logic         c_o,
  output logic         rise_c_o
);

  if (N < 1 || N > MULLER_MAX_INPUTS) begin : g_bad_n
    $error("muller_c_clk: N out of range");
  end

  logic c_q;
  logic c_d;

  always_comb begin
    c_d = c_next(c_state_t'(in_i), c_q, N);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) c_q <= 1'b0;
    else     c_q <= c_d;
  end

  assign c_o      = c_q;
  assign rise_c_o = ~c_q & c_d;

endmodule

// File: rtl/muller_pipe_clk.sv
// Clocked Muller micropipeline: DEPTH C-element stages with bundled-data registers.
// Optional input-protocol monitors are built when MULLER_PIPE_PROTOCOL_CHECK_EN is defined.
module muller_pipe_clk
  import muller_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IN_CH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IN_CH-1:0]       in_req,
  input  logic [IN_CH*WIDTH-1:0] in_data,
  output logic                   in_ack,
  output logic                   out_req,
  output logic [IN_CH*WIDTH-1:0] out_data,
  input  logic                   out_ack,
  output logic                   proto_err
);

  localparam int unsigned DW = IN_CH * WIDTH;

  if (DEPTH < MULLER_MIN_DEPTH) begin : g_bad_depth
    $error("muller_pipe_clk: DEPTH below minimum");
  end
  if (IN_CH < 1) begin : g_bad_in_ch
    $error("muller_pipe_clk: IN_CH must be at least 1");
  end

  logic [DEPTH-1:0] c_q;
  logic [DEPTH-1:0] rise_c;
  logic [DW-1:0]    data_q [DEPTH];

  // Stage 0 joins all input requests; the last stage listens to out_ack.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      muller_c_clk #(.N(IN_CH + 1)) u_c (
        .clk     (clk),
        .rst     (rst),
        .in_i    ({~c_q[1], in_req}),
        .c_o     (c_q[i]),
        .rise_c_o(rise_c[i])
      );
    end else if (i == DEPTH - 1) begin : g_last
      muller_c_clk #(.N(2)) u_c (
        .clk     (clk),
        .rst     (rst),
        .in_i    ({~out_ack, c_q[i-1]}),
        .c_o     (c_q[i]),
        .rise_c_o(rise_c[i])
      );
    end else begin : g_mid
      muller_c_clk #(.N(2)) u_c (
        .clk     (clk),
        .rst     (rst),
        .in_i    ({~c_q[i+1], c_q[i-1]}),
        .c_o     (c_q[i]),
        .rise_c_o(rise_c[i])
      );
    end
  end

  // Data moves only when a stage accepts a new token (0->1 on its C-element).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      if (rise_c[0]) data_q[0] <= in_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (rise_c[i]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign in_ack   = c_q[0];
  assign out_req  = c_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

`ifdef MULLER_PIPE_PROTOCOL_CHECK_EN
  logic [IN_CH-1:0] req_q;
  logic [DW-1:0]    dat_q;
  logic             err_q;
  logic             err_d;

  // Sticky flag: early request drop, early re-request, or data change while waiting.
  always_comb begin
    err_d = err_q;
    for (int unsigned j = 0; j < IN_CH; j++) begin
      if (req_q[j] && !in_req[j] && !c_q[0]) err_d = 1'b1;
      if (!req_q[j] && in_req[j] && c_q[0])  err_d = 1'b1;
      if (req_q[j] && in_req[j] && !c_q[0] &&
          (dat_q[j*WIDTH +: WIDTH] != in_data[j*WIDTH +: WIDTH])) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
      dat_q <= '0;
      err_q <= 1'b0;
    end else begin
      req_q <= in_req;
      dat_q <= in_data;
      err_q <= err_d;
    end
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_muller_pipe_clk.sv
// Directed and randomized bench for muller_pipe_clk (2 joined channels, DEPTH 4).
module tb_muller_pipe_clk;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IN_CH = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = IN_CH * WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [IN_CH-1:0] in_req = '0;
  logic [DW-1:0]    in_data = '0;
  logic             in_ack;
  logic             out_req;
  logic [DW-1:0]    out_data;
  logic             out_ack = 1'b0;
  logic             proto_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rnd_d;
  logic [DW-1:0] rnd_exp;
  logic          exp_proto;
  int            lat;

  muller_pipe_clk #(.WIDTH(WIDTH), .IN_CH(IN_CH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_req   (in_req),
    .in_data  (in_data),
    .in_ack   (in_ack),
    .out_req  (out_req),
    .out_data (out_data),
    .out_ack  (out_ack),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic v, input string tag);
    int n = 0;
    while (in_ack !== v && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(in_ack), 32'(v));
  endtask

  task automatic wait_oreq(input logic v, input string tag);
    int n = 0;
    while (out_req !== v && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(out_req), 32'(v));
  endtask

  task automatic push(input logic [DW-1:0] d, input string tag);
    in_data = d;
    in_req  = '1;
    wait_ack(1'b1, tag);
    in_req  = '0;
    wait_ack(1'b0, tag);
  endtask

  task automatic pop(input logic [DW-1:0] d, input string tag);
    wait_oreq(1'b1, tag);
    check(tag, 32'(out_data), 32'(d));
    out_ack = 1'b1;
    wait_oreq(1'b0, tag);
    out_ack = 1'b0;
  endtask

  initial begin
`ifdef MULLER_PIPE_PROTOCOL_CHECK_EN
    exp_proto = 1'b1;
`else
    exp_proto = 1'b0;
`endif
    // Reset state
    tick();
    tick();
    check("rst_in_ack", 32'(in_ack), 32'd0);
    check("rst_out_req", 32'(out_req), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_proto", 32'(proto_err), 32'd0);
    rst = 1'b0;

    // Forward latency through an empty pipe
    in_data = 16'h5AA5;
    in_req  = 2'b11;
    tick();
    check("lat_ack_e1", 32'(in_ack), 32'd1);
    check("lat_oreq_e1", 32'(out_req), 32'd0);
    tick();
    tick();
    check("lat_oreq_e3", 32'(out_req), 32'd0);
    tick();
    check("lat_oreq_e4", 32'(out_req), 32'd1);
    check("lat_data_e4", 32'(out_data), 32'h5AA5);
    in_req = '0;
    wait_ack(1'b0, "lat_ack_lo");
    pop(16'h5AA5, "lat_pop");

    // Capacity: two tokens fit, the third waits until the output drains
    push(16'h1111, "cap_push1");
    push(16'h2222, "cap_push2");
    in_data = 16'h3333;
    in_req  = 2'b11;
    repeat (10) tick();
    check("cap_full_ack", 32'(in_ack), 32'd0);
    pop(16'h1111, "cap_pop1");
    wait_ack(1'b1, "cap_third_ack");
    in_req = '0;
    wait_ack(1'b0, "cap_third_lo");
    pop(16'h2222, "cap_pop2");
    pop(16'h3333, "cap_pop3");

    // Join: one channel alone never acknowledges
    in_data = 16'hC33C;
    in_req  = 2'b01;
    repeat (5) tick();
    check("join_partial", 32'(in_ack), 32'd0);
    in_req = 2'b11;
    tick();
    check("join_full", 32'(in_ack), 32'd1);
    in_req = '0;
    wait_ack(1'b0, "join_lo");
    pop(16'hC33C, "join_pop");

    // Asynchronous reset with two tokens held
    push(16'hAAAA, "rmf_push1");
    push(16'hBBBB, "rmf_push2");
    #2;
    rst = 1'b1;
    #1;
    check("rmf_in_ack", 32'(in_ack), 32'd0);
    check("rmf_out_req", 32'(out_req), 32'd0);
    check("rmf_out_data", 32'(out_data), 32'd0);
    tick();
    rst     = 1'b0;
    in_data = 16'hD00D;
    in_req  = 2'b11;
    lat     = 0;
    while (out_req !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("rmf_latency", 32'(lat), 32'(DEPTH));
    check("rmf_data", 32'(out_data), 32'hD00D);
    in_req = '0;
    wait_ack(1'b0, "rmf_ack_lo");
    pop(16'hD00D, "rmf_pop");

    // Random traffic: FIFO order with a consumer acknowledging one cycle late
    fork
      begin
        for (int k = 0; k < 100; k++) begin
          rnd_d = DW'($urandom);
          repeat ($urandom_range(0, 2)) tick();
          in_data = rnd_d;
          if ($urandom_range(0, 1) == 1) begin
            in_req = 2'b01;
            tick();
          end
          in_req = 2'b11;
          wait_ack(1'b1, "rnd_ack_hi");
          exp_q.push_back(rnd_d);
          in_req = '0;
          wait_ack(1'b0, "rnd_ack_lo");
        end
      end
      begin
        for (int k = 0; k < 100; k++) begin
          wait_oreq(1'b1, "rnd_oreq_hi");
          tick();
          rnd_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
          check("rnd_data", 32'(out_data), 32'(rnd_exp));
          out_ack = 1'b1;
          wait_oreq(1'b0, "rnd_oreq_lo");
          out_ack = 1'b0;
        end
      end
    join
    check("rnd_all_drained", 32'(exp_q.size()), 32'd0);
    check("rnd_no_proto", 32'(proto_err), 32'd0);

    // Protocol violation: request dropped before acknowledge
    in_data = 16'h0F0F;
    in_req  = 2'b01;
    tick();
    in_req = 2'b00;
    tick();
    check("proto_set", 32'(proto_err), 32'(exp_proto));
    repeat (3) tick();
    check("proto_hold", 32'(proto_err), 32'(exp_proto));
    rst = 1'b1;
    #1;
    check("proto_rst", 32'(proto_err), 32'd0);
    tick();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muller_pipe_clk.md
# muller_pipe_clk

Clocked, parametrised Muller micropipeline for the async library: a chain of `DEPTH` N-input C-element stages, each with a `IN_CH*WIDTH`-bit bundled-data register, driven by 4-phase req/ack handshakes at both ends. Stage 0 is a generalised C-element that joins `IN_CH` input channels onto one shared acknowledge. The block is the synthesizable, single-clock successor to the 2-input C-element. It is used as an elastic buffer or join point between handshake domains on the one system clock.

## Interface
Parameters:
- `WIDTH`, 8: data bits per input channel.
- `IN_CH`, 1: number of joined input channels, ≥1.
- `DEPTH`, 4: number of pipeline stages, ≥2.

Ports:
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `in_req`, in, `IN_CH`: per-channel 4-phase request.
- `in_data`, in, `IN_CH*WIDTH`: bundled data; channel j occupies bits `[j*WIDTH +: WIDTH]`.
- `in_ack`, out, 1: shared acknowledge, equal to `c[0]`.
- `out_req`, out, 1: output request, equal to `c[DEPTH-1]`.
- `out_data`, out, `IN_CH*WIDTH`: equal to `data[DEPTH-1]`.
- `out_ack`, in, 1: output acknowledge.
- `proto_err`, out, 1: sticky input-protocol violation flag.

## Operation
- State per stage i: C-element bit `c[i]` and register `data[i]`.
- N-input C-element rule: the output becomes 1 if all inputs are 1, becomes 0 if all inputs are 0, and holds otherwise.
- Stage 0 inputs: `in_req[IN_CH-1:0]` and `~c[1]`.
- Stage i, for 0<i<DEPTH-1, inputs: `c[i-1]` and `~c[i+1]`.
- Stage DEPTH-1 inputs: `c[DEPTH-2]` and `~out_ack`.
- All `c[i]` next values are computed from current-cycle values and update simultaneously.
- Data capture happens only on a 0→1 transition of `c[i]`:
  - `data[0] <= in_data`.
  - `data[i] <= data[i-1]`.
- A 1→0 transition of `c[i]` leaves `data[i]` unchanged.
- Capacity is `ceil(DEPTH/2)` tokens with `out_ack` held low. When the pipe is full, a further `in_req` is not acknowledged and `in_ack` stays 0.
- Join behaviour: `in_ack` rises only when every `in_req[j]` is 1. It falls only when every `in_req[j]` is 0. Any mixed state holds `in_ack`.
- Reset (asynchronous, mid-operation included):
  - All `c[i]` and `data[i]` go to 0 and `proto_err` goes to 0.
  - So `in_ack`=0, `out_req`=0 and `out_data`=0 immediately.
  - Tokens in flight are discarded.
- Environment contract: `in_data` is stable from the `in_req` rise until `in_ack` rises. `in_req` does not fall before `in_ack` rises. `in_req` does not rise again before `in_ack` falls. Behaviour on violation is undefined except for `proto_err`.

## Timing
- Each stage makes at most one transition per clock.
- Forward latency in an empty pipe with `out_ack`=0: if `in_req` is all-1 before edge 1, then `in_ack`=1 after edge 1 and `out_req`=1 with valid `out_data` after edge DEPTH.
- `out_data` is stable whenever `out_req`=1 and `out_ack`=0.
- `out_ack` rising while `out_req`=1 clears `out_req` no earlier than the next edge, and only after `c[DEPTH-2]`=0.
- There are no combinational paths from inputs to outputs; all outputs are flop-driven.

## Configuration
- Macro: `MULLER_PIPE_PROTOCOL_CHECK_EN`.
- Defined: one monitor per channel j sets `proto_err` on the edge where any of these holds:
  - (a) `in_req[j]` falls while `in_ack`=0;
  - (b) `in_req[j]` rises while `in_ack`=1;
  - (c) `in_req[j]` was 1 on two consecutive edges with `in_ack`=0, and channel j's `in_data` slice changed between them.
- The monitors use one registered `in_req` bit and one `WIDTH`-bit data copy per channel.
- Once set, `proto_err` stays 1 until `rst`.
- Not defined: `proto_err` is tied to 0 and no monitor flops exist.

## Structure
- Shared package `muller_pkg`:
  - `MULLER_MIN_DEPTH` = 2.
  - Typedef `c_state_t` for the stage C-element vector.
  - Function `c_next(inputs, current)` implementing the C-element rule.
- Sub-module `muller_c_clk #(N)`: clocked N-input C-element with `clk` and `rst`. It is instantiated once per stage, with N=IN_CH+1 for stage 0 and N=2 elsewhere.
- Elaboration error if `DEPTH`<`MULLER_MIN_DEPTH` or `IN_CH`<1.

## Test plan
- Latency: DEPTH=4, IN_CH=1, out_ack=0, in_data=0xA5, in_req=1 before edge 1 → in_ack=1 after edge 1; out_req=1 and out_data=0xA5 after edge 4.
- Capacity: DEPTH=4, out_ack=0, push tokens 0x11, 0x22, 0x33 → first two acknowledged, third never gets in_ack; drain via out_ack handshakes → out_data 0x11, 0x22, then 0x33 once space frees.
- Join: IN_CH=2, in_req=2'b01 for 5 cycles → in_ack stays 0; in_req=2'b11 → in_ack=1 after next edge; out_data=={ch1,ch0}.
- Reset mid-flight: assert rst asynchronously with 2 tokens held → in_ack, out_req, out_data = 0 immediately; new token after release arrives DEPTH edges later.
- Throughput/order: 100 random tokens, out_ack responding one cycle after out_req → FIFO order preserved, no loss or duplication.
- Protocol check (macro defined): drop in_req before in_ack → proto_err=1 after that edge, held until rst; with macro undefined → proto_err stays 0.
